mac_array_seq: RTL and testbench
================================

// Module: mac_array_seq
// PURPOSE
//  Sequencer for the PAR-lane MAC array in the pointwise-conv compute path. On start it walks
//  N output groups x K accumulation steps, issuing activation/weight buffer reads and aligned
//  MAC valids, and tags the first step of each group. It also counts MAC results and hands
//  each finished group downstream with a valid/ready handshake.
// PARAMETERS
//  ADDR_W   12  activation/weight buffer address width
//  CNT_W    12  width of cfg_k_steps / cfg_n_groups and internal counters
//  RD_LAT   1   buffer read latency, cycles (>=1); mac_valid_in = rd_en delayed RD_LAT
// PORTS
//  clk            in   1       clock
//  rst            in   1       reset; one clock; reset is asynchronous and active-high
//  start          in   1       launch job; sampled only in IDLE
//  cfg_k_steps    in   CNT_W   accumulation steps per group (K)
//  cfg_n_groups   in   CNT_W   output groups per job (N)
//  busy           out  1       high from the cycle after start until done
//  done           out  1       1-cycle pulse at job end
//  cfg_err        out  1       1-cycle pulse: start with K==0 or N==0
//  act_rd_en      out  1       activation buffer read strobe
//  act_rd_addr    out  ADDR_W  = g*K + k (truncated to ADDR_W)
//  wgt_rd_en      out  1       weight buffer read strobe (same cycle as act_rd_en)
//  wgt_rd_addr    out  ADDR_W  = k (weights reused per group)
//  mac_valid_in   out  1       to MAC array valid_in
//  psum_first     out  1       with mac_valid_in: psum mux selects 0, else feeds back mac_out
//  mac_valid_out  in   1       from MAC array valid_out
//  out_valid      out  1       group result held in MAC registers is complete
//  out_last       out  1       qualifies out_valid: final group of job
//  out_ready      in   1       downstream accepts result when out_valid&&out_ready
// BEHAVIOUR
//  - Reset: FSM=IDLE, all counters 0, every output 0. Reset mid-job aborts; no done.
//  - FSM IDLE -> RUN (start, K,N != 0; cfg latched) | IDLE (start, K or N == 0: cfg_err
//    pulse next cycle, no reads, no done). RUN -> WAIT after issuing k=K-1.
//    WAIT -> RUN on result accept if g<N-1 (g++, k=0) | DONE on accept if g==N-1.
//    DONE -> IDLE after 1 cycle; done=1 in DONE.
//  - RUN: one read per cycle, k++ each cycle; rd_en/addr registered outputs.
//  - Alignment: mac_valid_in and psum_first are rd_en and (k==0) delayed by exactly RD_LAT.
//  - Result counter increments on mac_valid_out; when it reaches K, out_valid rises next
//    cycle, counter clears. out_valid/out_last held stable until out_ready.
//  - No issue for group g+1 until group g accepted (protects MAC accumulators).
//  - start while busy: ignored, no effect on counters or cfg.
//  - mac_valid_out with FSM in IDLE: ignored.
//  - K==1: every step has psum_first=1; out_valid after single result.
//  - Address arithmetic modulo 2^ADDR_W; no overflow flag.
// CONFIGURATION
//  MAC_SEQ_PERF_EN defined: adds out ports perf_busy_cyc[31:0] (cycles with busy=1) and
//   perf_stall_cyc[31:0] (cycles out_valid&&!out_ready); both clear on accepted start,
//   saturate at all-ones, reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  K=4,N=2,RD_LAT=1,out_ready=1, start@c0 -> rd c1-4 act 0..3 wgt 0..3; mac_valid_in c2-5,
//   psum_first c2 only; out_valid c7; rd c8-11 act 4..7 wgt 0..3; out_valid+out_last c14;
//   done c15.
//  Same job, out_ready low 5 cycles at first out_valid -> out_valid held, no reads until
//   accept, second group reads start cycle after accept.
//  K=0,N=3 start -> cfg_err pulse, busy stays 0, no rd_en, no done.
//  start pulses during RUN/WAIT -> ignored; address sequence and done unchanged.
//  rst asserted mid-RUN of K=8,N=4 -> all outputs 0 same cycle; new job runs clean.
//  RD_LAT=3,K=1,N=3 -> mac_valid_in 3 cycles after each rd_en, psum_first every step;
//   3 results, out_last on third.

Source files
------------

// File: rtl/mac_array_seq_if.sv
// Result handoff bundle between the MAC sequencer and the downstream writer.
// The master presents a finished group; the slave accepts it with out_ready.
interface mac_array_seq_if;
  logic out_valid;
  logic out_last;
  logic out_ready;

  modport master (
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/mac_array_seq.sv
// Sequencer for the PAR-lane MAC array: walks N groups x K steps, aligns MAC valids.
// Optional MAC_SEQ_PERF_EN adds saturating busy/stall cycle counters.
module mac_array_seq #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_k_steps,
  input  logic [CNT_W-1:0]  cfg_n_groups,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_rd_addr,
  output logic              mac_valid_in,
  output logic              psum_first,
  input  logic              mac_valid_out,
  mac_array_seq_if.master   out_if
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_busy_cyc,
  output logic [31:0]       perf_stall_cyc
`endif
);

  typedef enum logic [1:0] {
    IDLE, RUN, WAIT, DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] k_cfg_q, k_cfg_d;
  logic [CNT_W-1:0] n_cfg_q, n_cfg_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] g_q, g_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;

  logic              rd_en_q, rd_en_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] act_addr_q, act_addr_d;
  logic [ADDR_W-1:0] wgt_addr_q, wgt_addr_d;
  logic [RD_LAT-1:0] vpipe_q, vpipe_d;
  logic [RD_LAT-1:0] fpipe_q, fpipe_d;
  logic              cfg_err_q, cfg_err_d;
  logic              ov_q, ov_d;
  logic              ol_q, ol_d;

  logic cfg_ok;
  logic accept;
  logic last_k;
  logic last_g;

  assign cfg_ok = (cfg_k_steps != '0) && (cfg_n_groups != '0);
  assign accept = ov_q && out_if.out_ready;
  assign last_k = (k_q == k_cfg_q - CNT_W'(1));
  assign last_g = (g_q == n_cfg_q - CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    k_cfg_d    = k_cfg_q;
    n_cfg_d    = n_cfg_q;
    k_d        = k_q;
    g_d        = g_q;
    rd_en_d    = 1'b0;
    first_d    = 1'b0;
    act_addr_d = act_addr_q;
    wgt_addr_d = wgt_addr_q;
    cfg_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && cfg_ok) begin
          state_d    = RUN;
          k_cfg_d    = cfg_k_steps;
          n_cfg_d    = cfg_n_groups;
          k_d        = '0;
          g_d        = '0;
          rd_en_d    = 1'b1;
          first_d    = 1'b1;
          act_addr_d = '0;
          wgt_addr_d = '0;
        end else if (start) begin
          cfg_err_d = 1'b1;
        end
      end
      RUN: begin
        if (last_k) begin
          state_d = WAIT;
        end else begin
          k_d        = k_q + CNT_W'(1);
          rd_en_d    = 1'b1;
          act_addr_d = act_addr_q + ADDR_W'(1);
          wgt_addr_d = ADDR_W'(k_d);
        end
      end
      // Next group waits for acceptance so the accumulators are free.
      WAIT: begin
        if (accept && last_g) begin
          state_d = DONE;
        end else if (accept) begin
          state_d    = RUN;
          g_d        = g_q + CNT_W'(1);
          k_d        = '0;
          rd_en_d    = 1'b1;
          first_d    = 1'b1;
          act_addr_d = act_addr_q + ADDR_W'(1);
          wgt_addr_d = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vpipe_d = (vpipe_q << 1) | RD_LAT'(rd_en_q);
    fpipe_d = (fpipe_q << 1) | RD_LAT'(first_q);
    rcnt_d  = rcnt_q;
    ov_d    = ov_q;
    ol_d    = ol_q;
    if (accept) begin
      ov_d = 1'b0;
      ol_d = 1'b0;
    end
    if (mac_valid_out && (state_q != IDLE)) begin
      if (rcnt_q == k_cfg_q - CNT_W'(1)) begin
        rcnt_d = '0;
        ov_d   = 1'b1;
        ol_d   = last_g;
      end else begin
        rcnt_d = rcnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_cfg_q    <= '0;
      n_cfg_q    <= '0;
      k_q        <= '0;
      g_q        <= '0;
      rcnt_q     <= '0;
      rd_en_q    <= 1'b0;
      first_q    <= 1'b0;
      act_addr_q <= '0;
      wgt_addr_q <= '0;
      vpipe_q    <= '0;
      fpipe_q    <= '0;
      cfg_err_q  <= 1'b0;
      ov_q       <= 1'b0;
      ol_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_cfg_q    <= k_cfg_d;
      n_cfg_q    <= n_cfg_d;
      k_q        <= k_d;
      g_q        <= g_d;
      rcnt_q     <= rcnt_d;
      rd_en_q    <= rd_en_d;
      first_q    <= first_d;
      act_addr_q <= act_addr_d;
      wgt_addr_q <= wgt_addr_d;
      vpipe_q    <= vpipe_d;
      fpipe_q    <= fpipe_d;
      cfg_err_q  <= cfg_err_d;
      ov_q       <= ov_d;
      ol_q       <= ol_d;
    end
  end

  assign busy             = (state_q == RUN) || (state_q == WAIT);
  assign done             = (state_q == DONE);
  assign cfg_err          = cfg_err_q;
  assign act_rd_en        = rd_en_q;
  assign wgt_rd_en        = rd_en_q;
  assign act_rd_addr      = act_addr_q;
  assign wgt_rd_addr      = wgt_addr_q;
  assign mac_valid_in     = vpipe_q[RD_LAT-1];
  assign psum_first       = fpipe_q[RD_LAT-1];
  assign out_if.out_valid = ov_q;
  assign out_if.out_last  = ol_q;

`ifdef MAC_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if ((state_q == IDLE) && start && cfg_ok) begin
      perf_busy_d  = '0;
      perf_stall_d = '0;
    end else begin
      if (busy && (perf_busy_q != '1))
        perf_busy_d = perf_busy_q + 32'd1;
      if (ov_q && !out_if.out_ready && (perf_stall_q != '1))
        perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_busy_cyc  = perf_busy_q;
  assign perf_stall_cyc = perf_stall_q;
`endif

endmodule

// File: tb/tb_mac_array_seq.sv
// Scoreboard bench for mac_array_seq: RD_LAT=1 and RD_LAT=3 instances.
// Stimulus pushes expected events; negedge monitors pop and compare.
module tb_mac_array_seq;
  localparam int AW = 12;
  localparam int CW = 12;

  typedef struct {
    int c;
    int a;
    int b;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic          start, busy, done, cfg_err;
  logic [CW-1:0] cfg_k, cfg_n;
  logic          act_en, wgt_en, mvi, pf;
  logic          mvo;
  logic [AW-1:0] act_addr, wgt_addr;
  mac_array_seq_if oif ();

  logic          start3, busy3, done3, cfg_err3;
  logic [CW-1:0] cfg_k3, cfg_n3;
  logic          act_en3, wgt_en3, mvi3, pf3;
  logic          mvo3;
  logic [AW-1:0] act_addr3, wgt_addr3;
  mac_array_seq_if oif3 ();

  mac_array_seq #(.ADDR_W(AW), .CNT_W(CW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_k_steps(cfg_k), .cfg_n_groups(cfg_n),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .act_rd_en(act_en), .act_rd_addr(act_addr),
    .wgt_rd_en(wgt_en), .wgt_rd_addr(wgt_addr),
    .mac_valid_in(mvi), .psum_first(pf),
    .mac_valid_out(mvo), .out_if(oif)
  );

  mac_array_seq #(.ADDR_W(AW), .CNT_W(CW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .cfg_k_steps(cfg_k3), .cfg_n_groups(cfg_n3),
    .busy(busy3), .done(done3), .cfg_err(cfg_err3),
    .act_rd_en(act_en3), .act_rd_addr(act_addr3),
    .wgt_rd_en(wgt_en3), .wgt_rd_addr(wgt_addr3),
    .mac_valid_in(mvi3), .psum_first(pf3),
    .mac_valid_out(mvo3), .out_if(oif3)
  );

  // MAC array model: one-cycle compute latency
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mvo  <= 1'b0;
      mvo3 <= 1'b0;
    end else begin
      mvo  <= mvi;
      mvo3 <= mvi3;
    end
  end

  ev_t q_rd[$], q_mv[$], q_out[$], q_done[$], q_err[$];
  ev_t q3_rd[$], q3_mv[$], q3_out[$], q3_done[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    q_rd.delete(); q_mv.delete(); q_out.delete();
    q_done.delete(); q_err.delete();
  endtask

  // Ready-always timing: group period is K + RD_LAT + 2 cycles
  task automatic push_job(input int c0, input int k, input int n,
                          input int s, input int lat);
    int p;
    ev_t e;
    p = k + lat + 2;
    for (int g = 0; g < n; g++) begin
      for (int kk = 0; kk < k; kk++) begin
        e.c = c0 + 1 + g * p + kk + ((g > 0) ? s : 0);
        e.a = (g * k + kk) % 4096;
        e.b = kk;
        q_rd.push_back(e);
        e.c = e.c + lat;
        e.a = int'(kk == 0);
        e.b = 0;
        q_mv.push_back(e);
      end
      e.c = c0 + 1 + g * p + k + lat + 1 + s;
      e.a = int'(g == n - 1);
      e.b = 0;
      q_out.push_back(e);
    end
    e.c = c0 + n * p + 1 + s;
    e.a = 0;
    q_done.push_back(e);
  endtask

  task automatic run_job(input int k, input int n, input int s,
                         input bit noise);
    int c0;
    int bound;
    c0 = cyc;
    bound = n * (k + 10 + s) + 50;
    push_job(c0, k, n, s, 1);
    cfg_k = CW'(k);
    cfg_n = CW'(n);
    start = 1'b1;
    if (s > 0) oif.out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < bound && q_done.size() != 0; i++) begin
      if (noise && (cyc == c0 + 3 || cyc == c0 + 6)) begin
        cfg_k = CW'(7);
        cfg_n = CW'(9);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (s > 0 && cyc == c0 + k + 3 + s) oif.out_ready = 1'b1;
      tick();
    end
    start = 1'b0;
    oif.out_ready = 1'b1;
    repeat (3) tick();
    chk("done_timeout", q_done.size(), 0);
    chk("rd_left", q_rd.size(), 0);
    chk("mv_left", q_mv.size(), 0);
    chk("out_left", q_out.size(), 0);
    flush();
  endtask

  logic pov, plast, prdy;
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      pov = 1'b0; plast = 1'b0; prdy = 1'b1;
    end else begin
      if (act_en || wgt_en) chk("rd_en_pair", int'(wgt_en), int'(act_en));
      if (act_en) begin
        if (q_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          e = q_rd.pop_front();
          chk("rd_cycle", cyc, e.c);
          chk("act_addr", int'(act_addr), e.a);
          chk("wgt_addr", int'(wgt_addr), e.b);
        end
      end
      if (mvi) begin
        if (q_mv.size() == 0) chk("mv_unexpected", 1, 0);
        else begin
          e = q_mv.pop_front();
          chk("mv_cycle", cyc, e.c);
          chk("psum_first", int'(pf), e.a);
        end
      end
      if (pov && !prdy) begin
        chk("ov_hold", int'(oif.out_valid), 1);
        chk("last_hold", int'(oif.out_last), int'(plast));
      end
      if (oif.out_valid && oif.out_ready) begin
        if (q_out.size() == 0) chk("out_unexpected", 1, 0);
        else begin
          e = q_out.pop_front();
          chk("out_cycle", cyc, e.c);
          chk("out_last", int'(oif.out_last), e.a);
        end
      end
      if (done) begin
        if (q_done.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e = q_done.pop_front();
          chk("done_cycle", cyc, e.c);
        end
      end
      if (cfg_err) begin
        if (q_err.size() == 0) chk("err_unexpected", 1, 0);
        else begin
          e = q_err.pop_front();
          chk("err_cycle", cyc, e.c);
        end
      end
      pov = oif.out_valid; plast = oif.out_last; prdy = oif.out_ready;
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (cfg_err3) chk("err3_unexpected", 1, 0);
      if (act_en3) begin
        if (q3_rd.size() == 0) chk("rd3_unexpected", 1, 0);
        else begin
          e = q3_rd.pop_front();
          chk("rd3_cycle", cyc, e.c);
          chk("act3_addr", int'(act_addr3), e.a);
          chk("wgt3_addr", int'(wgt_addr3), 0);
        end
      end
      if (mvi3) begin
        if (q3_mv.size() == 0) chk("mv3_unexpected", 1, 0);
        else begin
          e = q3_mv.pop_front();
          chk("mv3_cycle", cyc, e.c);
          chk("psum3_first", int'(pf3), 1);
        end
      end
      if (oif3.out_valid && oif3.out_ready) begin
        if (q3_out.size() == 0) chk("out3_unexpected", 1, 0);
        else begin
          e = q3_out.pop_front();
          chk("out3_cycle", cyc, e.c);
          chk("out3_last", int'(oif3.out_last), e.a);
        end
      end
      if (done3) begin
        if (q3_done.size() == 0) chk("done3_unexpected", 1, 0);
        else begin
          e = q3_done.pop_front();
          chk("done3_cycle", cyc, e.c);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int c0;
    ev_t e;
    start = 1'b0; cfg_k = '0; cfg_n = '0;
    start3 = 1'b0; cfg_k3 = CW'(1); cfg_n3 = CW'(3);
    oif.out_ready = 1'b1;
    oif3.out_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_act_en", int'(act_en), 0);
    chk("rst_mvi", int'(mvi), 0);
    chk("rst_ov", int'(oif.out_valid), 0);
    chk("rst_busy3", int'(busy3), 0);
    rst = 1'b0;
    tick();

    // Reference job, then same job with a 5-cycle stall on the first result
    run_job(4, 2, 0, 1'b0);
    run_job(4, 2, 5, 1'b0);

    // Zero K: error pulse only
    c0 = cyc;
    e.c = c0 + 1; e.a = 0; e.b = 0;
    q_err.push_back(e);
    cfg_k = CW'(0); cfg_n = CW'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) begin
      chk("busy_on_err", int'(busy), 0);
      tick();
    end
    chk("err_left", q_err.size(), 0);

    // start pulses while busy must not disturb the job
    run_job(4, 2, 0, 1'b1);
    run_job(1, 3, 0, 1'b0);

    // Mid-RUN reset aborts cleanly
    c0 = cyc;
    push_job(c0, 8, 4, 0, 1);
    cfg_k = CW'(8); cfg_n = CW'(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_act_en", int'(act_en), 0);
    chk("arst_wgt_en", int'(wgt_en), 0);
    chk("arst_act_addr", int'(act_addr), 0);
    chk("arst_wgt_addr", int'(wgt_addr), 0);
    chk("arst_mvi", int'(mvi), 0);
    chk("arst_pf", int'(pf), 0);
    chk("arst_ov", int'(oif.out_valid), 0);
    chk("arst_done", int'(done), 0);
    flush();
    tick(); tick();
    rst = 1'b0;
    tick();
    run_job(3, 2, 0, 1'b0);

    // Address wrap past 4096 reads
    run_job(64, 65, 0, 1'b0);

    // RD_LAT=3, K=1, N=3: period 6
    c0 = cyc;
    for (int g = 0; g < 3; g++) begin
      e.c = c0 + 1 + 6 * g; e.a = g; e.b = 0;
      q3_rd.push_back(e);
      e.c = c0 + 4 + 6 * g; e.a = 1;
      q3_mv.push_back(e);
      e.c = c0 + 6 + 6 * g; e.a = int'(g == 2);
      q3_out.push_back(e);
    end
    e.c = c0 + 19; e.a = 0;
    q3_done.push_back(e);
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 100 && q3_done.size() != 0; i++) tick();
    repeat (3) tick();
    chk("done3_timeout", q3_done.size(), 0);
    chk("rd3_left", q3_rd.size(), 0);
    chk("mv3_left", q3_mv.size(), 0);
    chk("out3_left", q3_out.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
